tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receiving end of the time-multiplexed link that our mux2to1 drives. The mux toggles its selection line and places d0 and d1 alternately on one shared wire.
- tdm_demux samples that shared line slot by slot and rebuilds one registered copy per channel. It feeds the microwave control/display logic one level up.
- It locks to a frame-sync pulse that marks slot 0 and then free-runs, wrapping modulo CHANNELS.

Parameters:
- WIDTH, 1, width of the shared line and of each channel word
- CHANNELS, 2, number of time slots per frame (minimum 2)
- SLOT_W, 1, width of the slot index; must satisfy 2**SLOT_W >= CHANNELS

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  slot advance strobe; one slot is consumed per clk cycle with enable=1
- frame_sync  input  1  high during the cycle that carries slot 0
- line_in  input  WIDTH  shared multiplexed line
- ch_data  output  CHANNELS*WIDTH  reconstructed channel words; channel k occupies bits [k*WIDTH +: WIDTH]
- ch_valid  output  CHANNELS  one-cycle pulse; bit k is high the cycle after channel k is updated
- slot  output  SLOT_W  index of the slot expected next
- locked  output  1  high while in the LOCKED state
- frame_done  output  1  one-cycle pulse after the last slot (CHANNELS-1) is captured
- sync_err  output  1  one-cycle pulse when frame_sync arrives at slot != 0 while locked

Behaviour:
- Reset (asynchronous, rst_n=0): all of the following are cleared immediately, regardless of clk.
  - ch_data=0, ch_valid=0, slot=0, locked=0, frame_done=0, sync_err=0.
  - State returns to HUNT.
- Reset mid-frame discards the partial frame. Capture restarts only at the next frame_sync.
- All outputs are registered. A capture from line_in is visible on ch_data, ch_valid, frame_done and sync_err one clk after the sampling edge.
- enable=0 has the following effects:
  - No capture, and slot, state and ch_data hold.
  - ch_valid, frame_done and sync_err are 0 in the following cycle.
  - frame_sync is ignored.
- State machine, two states:
  - HUNT
    - enable=1 and frame_sync=1: capture line_in into channel 0, pulse ch_valid[0], set slot=1, go to LOCKED.
    - Otherwise: remain in HUNT, slot=0, no capture.
  - LOCKED, enable=1, frame_sync=0
    - Capture line_in into channel slot and pulse ch_valid[slot].
    - If slot==CHANNELS-1: set slot=0 and pulse frame_done.
    - Otherwise: slot increments by 1.
  - LOCKED, enable=1, frame_sync=1, slot==0
    - Normal slot-0 capture. No error.
  - LOCKED, enable=1, frame_sync=1, slot!=0 (resync)
    - Capture into channel 0, pulse ch_valid[0], pulse sync_err, set slot=1, remain in LOCKED.
    - No frame_done for the abandoned frame.
- Boundary cases:
  - frame_sync together with capture of the last slot: the resync rule wins. The capture goes to channel 0, not channel CHANNELS-1.
  - frame_sync is optional once LOCKED; the block free-runs.
  - LOCKED is left only by reset.
- Unwritten channels keep their last value; no clearing between frames.
- Exactly one ch_valid bit is high per capturing cycle. frame_done and ch_valid[CHANNELS-1] are coincident.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_HUNT=1'b0, ST_LOCKED=1'b1
  - default CHANNELS and WIDTH for the microwave link, so mux-side and demux-side instances agree
- One natural sub-module, tdm_slot_counter, which owns:
  - the modulo-CHANNELS counter
  - load-to-1 on sync
  - the wrap flag that drives frame_done
- Capture registers and the FSM stay in tdm_demux.

Test Plan:
- Reset and hunt: assert rst_n=0 asynchronously mid-cycle, then release; toggle line_in for 5 cycles with frame_sync=0. Required: all outputs 0 and locked=0 throughout.
- Basic lock, WIDTH=1, CHANNELS=2: frame_sync=1 with line_in=1, then line_in=0. Required:
  - after the first edge, ch_data=2'b01, ch_valid=2'b01, locked=1, slot=1;
  - after the second edge, ch_data=2'b01, ch_valid=2'b10, frame_done=1, slot=0.
- Mux round-trip: drive line_in from mux2to1 with selection toggling each clk, using the pairs (d0,d1) = (0,0), (1,0), (1,1), (0,1). Required: ch_data[0]=d0 and ch_data[1]=d1 one frame later for every pair.
- Enable stall: LOCKED at slot=1, then enable=0 for 3 cycles with line_in changing. Required:
  - ch_data, slot and locked unchanged, and ch_valid=0 during the stall;
  - the capture on the first enable=1 cycle lands in channel 1.
- Resync: CHANNELS=4, frame_sync=1 at slot=2 with line_in=1. Required: ch_data[0]=1, ch_valid=4'b0001, sync_err=1, frame_done=0, slot=1.
- Reset mid-frame: rst_n=0 at slot=1, then release. Required:
  - locked=0 and ch_data=0;
  - line_in is ignored until the next frame_sync.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the microwave TDM link: FSM encoding and the
// default geometry that the mux-side and demux-side instances must agree on.
package tdm_demux_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_WIDTH    = 1;
    localparam int TDM_CHANNELS = 2;
    localparam int TDM_SLOT_W   = 1;

endpackage : tdm_demux_pkg

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter: loads 1 on a sync capture, advances on a
// free-running capture, and flags the last slot so the frame can be closed.
module tdm_slot_counter #(
    parameter int CHANNELS = 2,
    parameter int SLOT_W   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_one_i,
    input  logic              advance_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              wrap_o
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        // A sync capture fills slot 0, so the next expected slot is 1.
        if (load_one_i) begin
            slot_d = ONE;
        end else if (advance_i) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign wrap_o = (slot_q == LAST_SLOT);

endmodule : tdm_slot_counter

// File: rtl/tdm_demux.sv
// Receive side of the TDM link: hunts for frame_sync, then rebuilds one
// registered word per channel from the shared line, slot by slot.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH    = TDM_WIDTH,
    parameter int CHANNELS = TDM_CHANNELS,
    parameter int SLOT_W   = TDM_SLOT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      frame_sync,
    input  logic [WIDTH-1:0]          line_in,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic [SLOT_W-1:0]         slot,
    output logic                      locked,
    output logic                      frame_done,
    output logic                      sync_err
);

    tdm_state_e                state_q, state_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;
    logic                      load_one;
    logic                      advance;
    logic                      wrap;
    logic [SLOT_W-1:0]         slot_cur;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .SLOT_W   (SLOT_W)
    ) u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_one_i (load_one),
        .advance_i  (advance),
        .slot_o     (slot_cur),
        .wrap_o     (wrap)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        valid_d      = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        load_one     = 1'b0;
        advance      = 1'b0;
        if (enable) begin
            if (frame_sync) begin
                // Sync always wins, even over the last slot of a frame.
                data_d[0 +: WIDTH] = line_in;
                valid_d[0]         = 1'b1;
                load_one           = 1'b1;
                sync_err_d         = (state_q == ST_LOCKED) && (slot_cur != '0);
                state_d            = ST_LOCKED;
            end else if (state_q == ST_LOCKED) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (slot_cur == SLOT_W'(k)) begin
                        data_d[k*WIDTH +: WIDTH] = line_in;
                        valid_d[k]               = 1'b1;
                    end
                end
                advance      = 1'b1;
                frame_done_d = wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            data_q       <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = data_q;
    assign ch_valid   = valid_q;
    assign slot       = slot_cur;
    assign locked     = (state_q == ST_LOCKED);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a 2-channel and a 4-channel instance share one stimulus
// stream and are checked every cycle against a frame-level reference model.
module tb_tdm_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic frame_sync = 1'b0;
    logic line_in = 1'b0;

    logic [1:0] ch_data2, ch_valid2;
    logic [0:0] slot2;
    logic       locked2, frame_done2, sync_err2;
    logic [3:0] ch_data4, ch_valid4;
    logic [1:0] slot4;
    logic       locked4, frame_done4, sync_err4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(1), .CHANNELS(2), .SLOT_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_sync(frame_sync),
        .line_in(line_in), .ch_data(ch_data2), .ch_valid(ch_valid2),
        .slot(slot2), .locked(locked2), .frame_done(frame_done2), .sync_err(sync_err2)
    );

    tdm_demux #(.WIDTH(1), .CHANNELS(4), .SLOT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_sync(frame_sync),
        .line_in(line_in), .ch_data(ch_data4), .ch_valid(ch_valid4),
        .slot(slot4), .locked(locked4), .frame_done(frame_done4), .sync_err(sync_err4)
    );

    // Reference model, index 0 = 2-channel instance, index 1 = 4-channel.
    int         nch[2] = '{2, 4};
    logic [3:0] m_data[2]  = '{4'd0, 4'd0};
    logic [3:0] m_valid[2] = '{4'd0, 4'd0};
    int         m_slot[2]  = '{0, 0};
    bit         m_locked[2] = '{0, 0};
    bit         m_fd[2] = '{0, 0};
    bit         m_se[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_data[i] = '0; m_valid[i] = '0; m_slot[i] = 0;
                m_locked[i] = 0; m_fd[i] = 0; m_se[i] = 0;
            end else begin
                m_valid[i] = '0; m_fd[i] = 0; m_se[i] = 0;
                if (enable && frame_sync) begin
                    m_se[i] = m_locked[i] && (m_slot[i] != 0);
                    m_data[i][0] = line_in;
                    m_valid[i] = 4'b0001;
                    m_slot[i] = 1;
                    m_locked[i] = 1;
                end else if (enable && m_locked[i]) begin
                    m_data[i][m_slot[i]] = line_in;
                    m_valid[i] = 4'b0001 << m_slot[i];
                    m_fd[i] = (m_slot[i] == nch[i] - 1);
                    m_slot[i] = (m_slot[i] + 1) % nch[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dut2.ch_data",    32'(ch_data2),    32'(m_data[0]));
        chk("dut2.ch_valid",   32'(ch_valid2),   32'(m_valid[0]));
        chk("dut2.slot",       32'(slot2),       32'(m_slot[0]));
        chk("dut2.locked",     32'(locked2),     32'(m_locked[0]));
        chk("dut2.frame_done", 32'(frame_done2), 32'(m_fd[0]));
        chk("dut2.sync_err",   32'(sync_err2),   32'(m_se[0]));
        chk("dut4.ch_data",    32'(ch_data4),    32'(m_data[1]));
        chk("dut4.ch_valid",   32'(ch_valid4),   32'(m_valid[1]));
        chk("dut4.slot",       32'(slot4),       32'(m_slot[1]));
        chk("dut4.locked",     32'(locked4),     32'(m_locked[1]));
        chk("dut4.frame_done", 32'(frame_done4), 32'(m_fd[1]));
        chk("dut4.sync_err",   32'(sync_err4),   32'(m_se[1]));
    end

    // Called at a falling edge; returns at the next falling edge, after the
    // rising edge that consumed these inputs.
    task automatic step(input logic e, input logic f, input logic l);
        enable = e; frame_sync = f; line_in = l;
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".ch_data2"},  32'(ch_data2),  32'h0);
        chk({tag, ".locked2"},   32'(locked2),   32'h0);
        chk({tag, ".slot2"},     32'(slot2),     32'h0);
        chk({tag, ".ch_valid2"}, 32'(ch_valid2), 32'h0);
        chk({tag, ".ch_data4"},  32'(ch_data4),  32'h0);
        chk({tag, ".locked4"},   32'(locked4),   32'h0);
        chk({tag, ".slot4"},     32'(slot4),     32'h0);
    endtask

    logic [1:0] pairs[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cleared("reset");

        // Hunt: line toggles without frame_sync, nothing may be captured.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'(i % 2));
            chk("hunt.locked2", 32'(locked2), 32'h0);
            chk("hunt.ch_data2", 32'(ch_data2), 32'h0);
            chk("hunt.ch_valid4", 32'(ch_valid4), 32'h0);
        end

        // Basic lock.
        step(1'b1, 1'b1, 1'b1);
        chk("lock1.ch_data2", 32'(ch_data2), 32'h1);
        chk("lock1.ch_valid2", 32'(ch_valid2), 32'h1);
        chk("lock1.locked2", 32'(locked2), 32'h1);
        chk("lock1.slot2", 32'(slot2), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        chk("lock2.ch_data2", 32'(ch_data2), 32'h1);
        chk("lock2.ch_valid2", 32'(ch_valid2), 32'h2);
        chk("lock2.frame_done2", 32'(frame_done2), 32'h1);
        chk("lock2.slot2", 32'(slot2), 32'h0);
        chk("lock2.frame_done4", 32'(frame_done4), 32'h0);
        chk("lock2.slot4", 32'(slot4), 32'h2);

        // Stall at slot 1 of the 2-channel instance.
        step(1'b1, 1'b0, 1'b1);
        chk("pre_stall.slot2", 32'(slot2), 32'h1);
        chk("pre_stall.ch_data4", 32'(ch_data4), 32'h5);
        step(1'b0, 1'b0, 1'b0);
        chk("stall.ch_valid2", 32'(ch_valid2), 32'h0);
        step(1'b0, 1'b1, 1'b1);
        chk("stall.slot2", 32'(slot2), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("stall.ch_data2", 32'(ch_data2), 32'h1);
        chk("stall.locked2", 32'(locked2), 32'h1);
        chk("stall.slot4", 32'(slot4), 32'h3);
        step(1'b1, 1'b0, 1'b1);
        chk("post_stall.ch_data2", 32'(ch_data2), 32'h3);
        chk("post_stall.ch_valid2", 32'(ch_valid2), 32'h2);
        chk("post_stall.ch_data4", 32'(ch_data4), 32'hd);
        chk("post_stall.frame_done4", 32'(frame_done4), 32'h1);

        // Mux round-trip: selection toggles each clock, d0 then d1.
        for (int p = 0; p < 4; p++) begin
            logic [1:0] pr;
            pr = pairs[p];
            step(1'b1, 1'b0, pr[0]);
            step(1'b1, 1'b0, pr[1]);
            chk("mux.ch_data2", 32'(ch_data2), 32'(pr));
        end
        chk("mux.ch_data4", 32'(ch_data4), 32'hb);

        // Resync mid-frame on the 4-channel instance (slot 2).
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("resync_pre.slot4", 32'(slot4), 32'h2);
        step(1'b1, 1'b1, 1'b1);
        chk("resync.ch_data4", 32'(ch_data4), 32'h9);
        chk("resync.ch_valid4", 32'(ch_valid4), 32'h1);
        chk("resync.sync_err4", 32'(sync_err4), 32'h1);
        chk("resync.frame_done4", 32'(frame_done4), 32'h0);
        chk("resync.slot4", 32'(slot4), 32'h1);
        chk("resync.sync_err2", 32'(sync_err2), 32'h0);

        // Sync coinciding with the last slot: capture goes to channel 0.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("lastsync.ch_data4", 32'(ch_data4), 32'h8);
        chk("lastsync.ch_valid4", 32'(ch_valid4), 32'h1);
        chk("lastsync.frame_done4", 32'(frame_done4), 32'h0);
        chk("lastsync.sync_err2", 32'(sync_err2), 32'h1);
        chk("lastsync.frame_done2", 32'(frame_done2), 32'h0);
        chk("lastsync.ch_valid2", 32'(ch_valid2), 32'h1);

        // Asynchronous reset mid-frame, away from any clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_cleared("async_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("rehunt.locked2", 32'(locked2), 32'h0);
            chk("rehunt.ch_data4", 32'(ch_data4), 32'h0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("relock.locked4", 32'(locked4), 32'h1);
        chk("relock.ch_data2", 32'(ch_data2), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tdm_demux
